// File: rtl/lcd_msg_formatter_if.sv
// Byte stream from the message formatter to the LCD writer.
// The writer pulls one command/character byte per valid/ready transfer.
interface lcd_msg_formatter_if;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       out_rs;

   modport master (output out_valid, output out_data, output out_rs, input out_ready);
   modport slave  (input out_valid, input out_data, input out_rs, output out_ready);
endinterface

// File: rtl/lcd_msg_formatter.sv
// Formats two register operands and an ALU result into a 31-byte LCD
// command/character stream (clear, line 1 hex, line 2 "ALU=" hex).
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; outputs parked at 0x00 / rs=0
// SEND  | presenting byte idx of the message until the writer takes it
module lcd_msg_formatter (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   input  logic [31:0]                 read_register_1,
   input  logic [31:0]                 read_register_2,
   input  logic [31:0]                 ALU_result,
   lcd_msg_formatter_if.master         lcd,
   output logic                        busy,
   output logic                        done
);

   typedef enum logic {IDLE, SEND} state_t;

   localparam logic [4:0] LAST_IDX = 5'd30;

   state_t      state_q, state_n;
   logic [4:0]  idx_q, idx_n;
   logic [31:0] r1_q, r1_n;
   logic [31:0] r2_q, r2_n;
   logic [31:0] alu_q, alu_n;
   logic        valid_q, valid_n;
   logic [7:0]  data_q, data_n;
   logic        rs_q, rs_n;
   logic        busy_q, busy_n;
   logic        done_q, done_n;

   logic [4:0]  lk_idx;
   logic [2:0]  lk_nib;
   logic [7:0]  lk_data;
   logic        lk_rs;

   function automatic logic [7:0] hex_char(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
   endfunction

   // Byte that follows the one currently presented, built from the captured operands.
   assign lk_idx = idx_q + 5'd1;

   always_comb begin
      lk_data = 8'h00;
      lk_rs   = 1'b0;
      lk_nib  = 3'd0;
      if (lk_idx == 5'd1) begin
         lk_data = 8'h80;
      end else if (lk_idx <= 5'd9) begin
         lk_nib  = 3'(5'd9 - lk_idx);
         lk_data = hex_char(r1_q[{lk_nib, 2'b00} +: 4]);
         lk_rs   = 1'b1;
      end else if (lk_idx <= 5'd17) begin
         lk_nib  = 3'(5'd17 - lk_idx);
         lk_data = hex_char(r2_q[{lk_nib, 2'b00} +: 4]);
         lk_rs   = 1'b1;
      end else if (lk_idx == 5'd18) begin
         lk_data = 8'hC0;
      end else if (lk_idx <= 5'd22) begin
         lk_rs = 1'b1;
         case (lk_idx)
            5'd19:   lk_data = 8'h41;
            5'd20:   lk_data = 8'h4C;
            5'd21:   lk_data = 8'h55;
            default: lk_data = 8'h3D;
         endcase
      end else begin
         lk_nib  = 3'(5'd30 - lk_idx);
         lk_data = hex_char(alu_q[{lk_nib, 2'b00} +: 4]);
         lk_rs   = 1'b1;
      end
   end

   always_comb begin
      state_n = state_q;
      idx_n   = idx_q;
      r1_n    = r1_q;
      r2_n    = r2_q;
      alu_n   = alu_q;
      valid_n = valid_q;
      data_n  = data_q;
      rs_n    = rs_q;
      busy_n  = busy_q;
      done_n  = 1'b0;
      case (state_q)
         IDLE: begin
            valid_n = 1'b0;
            data_n  = 8'h00;
            rs_n    = 1'b0;
            busy_n  = 1'b0;
            if (start) begin
               r1_n    = read_register_1;
               r2_n    = read_register_2;
               alu_n   = ALU_result;
               idx_n   = 5'd0;
               state_n = SEND;
               valid_n = 1'b1;
               data_n  = 8'h01;
               busy_n  = 1'b1;
            end
         end
         SEND: begin
            if (lcd.out_ready) begin
               if (idx_q == LAST_IDX) begin
                  state_n = IDLE;
                  idx_n   = 5'd0;
                  valid_n = 1'b0;
                  data_n  = 8'h00;
                  rs_n    = 1'b0;
                  busy_n  = 1'b0;
                  done_n  = 1'b1;
               end else begin
                  idx_n  = lk_idx;
                  data_n = lk_data;
                  rs_n   = lk_rs;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= 5'd0;
         r1_q    <= 32'h0;
         r2_q    <= 32'h0;
         alu_q   <= 32'h0;
         valid_q <= 1'b0;
         data_q  <= 8'h00;
         rs_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_n;
         idx_q   <= idx_n;
         r1_q    <= r1_n;
         r2_q    <= r2_n;
         alu_q   <= alu_n;
         valid_q <= valid_n;
         data_q  <= data_n;
         rs_q    <= rs_n;
         busy_q  <= busy_n;
         done_q  <= done_n;
      end
   end

   assign lcd.out_valid = valid_q;
   assign lcd.out_data  = data_q;
   assign lcd.out_rs    = rs_q;
   assign busy          = busy_q;
   assign done          = done_q;

endmodule
